// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// instruction field codes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] R15     = 4'd15;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // Returns {supported, alucontrol}; unsupported commands decode as NOPs.
    function automatic logic [2:0] decode_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return {1'b1, ALU_ADD};
            CMD_SUB: return {1'b1, ALU_SUB};
            CMD_CMP: return {1'b1, ALU_SUB};
            CMD_AND: return {1'b1, ALU_AND};
            CMD_ORR: return {1'b1, ALU_ORR};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_condlogic.sv
// NZCV flag register plus condition evaluation; flag writes are masked by condex.
module condlogic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic [1:0] flagw,     // [1]=load N,Z  [0]=load C,V
    output logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flagw[1] && condex) flags[3:2] <= aluflags[3:2];
            if (flagw[0] && condex) flags[1:0] <= aluflags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencer for the shared-ALU / unified-memory datapath: state register,
// per-state select and enable decode, and the flag-write request to condlogic.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] alucontrol,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [3:0] flags,
    output logic [3:0] state
);

    state_t     st;
    logic       condex;
    logic [1:0] flagw;
    logic       cmd_ok;
    logic [1:0] cmd_alu;
    logic [3:0] cmd;
    logic       pcw, mw, irw, rw;

    assign cmd               = funct[4:1];
    assign {cmd_ok, cmd_alu} = decode_cmd(cmd);
    assign state             = st;

    condlogic u_condlogic (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .aluflags (aluflags),
        .flagw    (flagw),
        .flags    (flags),
        .condex   (condex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH:  st <= DECODE;
                DECODE: begin
                    case (op)
                        OP_MEM:  st <= MEMADR;
                        OP_DP:   st <= funct[5] ? EXECUTEI : EXECUTER;
                        OP_BR:   st <= BRANCH;
                        default: st <= FETCH;
                    endcase
                end
                MEMADR:   st <= funct[0] ? MEMRD : MEMWR;
                MEMRD:    st <= MEMWB;
                EXECUTER: st <= ALUWB;
                EXECUTEI: st <= ALUWB;
                default:  st <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcw        = 1'b0;
        mw         = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        alucontrol = ALU_ADD;
        immsrc     = IMM_8;
        regsrc     = 2'b00;
        flagw      = 2'b00;
        case (st)
            FETCH: begin
                irw       = 1'b1;
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                pcw       = 1'b1;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                regsrc    = {op == OP_MEM, op == OP_BR};
                immsrc    = op;
            end
            MEMADR: begin
                alusrcb = SRCB_IMM;
                immsrc  = IMM_12;
            end
            MEMRD: adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = RES_DATA;
                rw        = condex;
                pcw       = condex && (rd == R15);
            end
            MEMWR: begin
                adrsrc = 1'b1;
                mw     = condex;
            end
            EXECUTER, EXECUTEI: begin
                alucontrol = cmd_alu;
                if (st == EXECUTEI) alusrcb = SRCB_IMM;
                // Logical ops only refresh N,Z; arithmetic ops refresh all four.
                if (cmd_ok && (funct[0] || cmd == CMD_CMP))
                    flagw = (cmd == CMD_AND || cmd == CMD_ORR) ? 2'b10 : 2'b11;
            end
            ALUWB: begin
                resultsrc = RES_ALUOUT;
                rw        = condex && cmd_ok && (cmd != CMD_CMP);
                pcw       = condex && cmd_ok && (cmd != CMD_CMP) && (rd == R15);
            end
            BRANCH: begin
                regsrc    = 2'b01;
                alusrcb   = SRCB_IMM;
                immsrc    = IMM_24;
                resultsrc = RES_ALU;
                pcw       = condex;
            end
            default: ;
        endcase
    end

    assign pcwrite  = pcw & ~reset;
    assign memwrite = mw & ~reset;
    assign irwrite  = irw & ~reset;
    assign regwrite = rw & ~reset;

endmodule
